// File: rtl/i2c_ack_monitor.sv
// i2c_ack_monitor
//   Watches one I2C acknowledge bit. After wait_ack arms it, the monitor waits
//   for SCL to go low, then for the next SCL rising edge. It then takes a
//   majority vote over SAMPLES consecutive SDA samples while SCL stays high and
//   reports ACK (SDA low) or N_ACK (SDA high) with a one-cycle ack_valid pulse.
//   An SCL high phase shorter than SAMPLES cycles is treated as a glitch and
//   ignored.
//
//   Optional feature, macro I2C_ACK_TIMEOUT_EN: bounds the wait for the SCL
//   rising edge to TIMEOUT_CYCLES cycles. On expiry the monitor reports N_ACK
//   with timeout and ack_valid pulsed together. Without the macro, timeout is
//   tied low and the wait is unbounded.
//
// Parameters
//   SAMPLES        - SDA samples per SCL high phase (odd, 1..15)
//   TIMEOUT_CYCLES - cycles from arm to SCL rising edge (2..65535)
// Ports
//   CLK       in  - sole clock, rising edge
//   RST       in  - synchronous active-high reset
//   wait_ack  in  - level enable, arms detection of one ACK bit
//   SDA       in  - asynchronous I2C data line
//   BUS_CLK   in  - asynchronous I2C SCL level (sampled as data)
//   ACK       out - last decision was acknowledge
//   N_ACK     out - last decision was not-acknowledge
//   ack_valid out - one-cycle pulse per decision
//   busy      out - armed and waiting/filtering
//   timeout   out - one-cycle pulse on a timeout decision
module i2c_ack_monitor #(
   parameter int unsigned SAMPLES        = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic CLK,
   input  logic RST,
   input  logic wait_ack,
   input  logic SDA,
   input  logic BUS_CLK,
   output logic ACK,
   output logic N_ACK,
   output logic ack_valid,
   output logic busy,
   output logic timeout
);

   localparam int unsigned CW = $clog2(SAMPLES + 1);

   typedef enum logic [2:0] {IDLE, ARM, WAIT_RISE, FILTER, DONE} state_t;

   state_t        state_q, state_d;
   logic [1:0]    sda_sync, scl_sync;
   logic          sda_s, scl_s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] ones_q, ones_d;
   logic [CW-1:0] ones_tot;
   logic          decide;
   logic          ack_q, ack_d;
   logic          nack_q, nack_d;
   logic          valid_q, valid_d;

   assign sda_s = sda_sync[1];
   assign scl_s = scl_sync[1];

`ifdef I2C_ACK_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          tmo_q, tmo_d;
   logic          tmo_hit;
   assign tmo_hit = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
   assign timeout = tmo_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         sda_sync <= '0;
         scl_sync <= '0;
         state_q  <= IDLE;
         cnt_q    <= '0;
         ones_q   <= '0;
         ack_q    <= 1'b0;
         nack_q   <= 1'b0;
         valid_q  <= 1'b0;
`ifdef I2C_ACK_TIMEOUT_EN
         tcnt_q   <= '0;
         tmo_q    <= 1'b0;
`endif
      end else begin
         sda_sync <= {sda_sync[0], SDA};
         scl_sync <= {scl_sync[0], BUS_CLK};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ones_q   <= ones_d;
         ack_q    <= ack_d;
         nack_q   <= nack_d;
         valid_q  <= valid_d;
`ifdef I2C_ACK_TIMEOUT_EN
         tcnt_q   <= tcnt_d;
         tmo_q    <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ones_d   = ones_q;
      ack_d    = ack_q;
      nack_d   = nack_q;
      valid_d  = 1'b0;
      decide   = 1'b0;
      ones_tot = '0;
`ifdef I2C_ACK_TIMEOUT_EN
      tcnt_d   = tcnt_q;
      tmo_d    = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (wait_ack) begin
               state_d = ARM;
               ack_d   = 1'b0;
               nack_d  = 1'b0;
            end
         end
         ARM: begin
            if (!wait_ack)  state_d = IDLE;
            else if (!scl_s) state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            // Entered only with scl_s low, so scl_s high here is the rising edge.
            // The rise cycle itself supplies the first vote, which lets the
            // decision land SAMPLES cycles after SCL is first seen high.
            if (!wait_ack) begin
               state_d = IDLE;
            end else if (scl_s) begin
               ones_tot = CW'(sda_s);
               if (SAMPLES == 1) begin
                  decide = 1'b1;
               end else begin
                  state_d = FILTER;
                  cnt_d   = CW'(1);
                  ones_d  = ones_tot;
               end
            end
         end
         FILTER: begin
            if (!wait_ack) begin
               state_d = IDLE;
            end else if (!scl_s) begin
               state_d = WAIT_RISE;   // high phase too short: discard votes
            end else begin
               ones_tot = ones_q + CW'(sda_s);
               if (cnt_q == CW'(SAMPLES - 1)) begin
                  decide = 1'b1;
               end else begin
                  cnt_d  = cnt_q + CW'(1);
                  ones_d = ones_tot;
               end
            end
         end
         DONE: begin
            if (!wait_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (decide) begin
         nack_d  = (ones_tot > CW'(SAMPLES / 2));
         ack_d   = !(ones_tot > CW'(SAMPLES / 2));
         valid_d = 1'b1;
         state_d = DONE;
      end

`ifdef I2C_ACK_TIMEOUT_EN
      // Timer covers ARM and WAIT_RISE only; it holds through FILTER so a
      // rejected glitch does not restart the allowance. Expiry outranks a
      // simultaneous rising edge; abort via wait_ack outranks both.
      if (state_q == IDLE && wait_ack) begin
         tcnt_d = '0;
      end else if ((state_q == ARM || state_q == WAIT_RISE) && wait_ack) begin
         if (tmo_hit) begin
            state_d = DONE;
            ack_d   = 1'b0;
            nack_d  = 1'b1;
            valid_d = 1'b1;
            tmo_d   = 1'b1;
            cnt_d   = cnt_q;
            ones_d  = ones_q;
         end else begin
            tcnt_d = tcnt_q + TW'(1);
         end
      end
`endif
   end

   assign ACK       = ack_q;
   assign N_ACK     = nack_q;
   assign ack_valid = valid_q;
   assign busy      = (state_q == ARM) || (state_q == WAIT_RISE) || (state_q == FILTER);

endmodule

// File: tb/tb_i2c_ack_monitor.sv
// tb_i2c_ack_monitor
//   Directed bench for i2c_ack_monitor (SAMPLES=3, TIMEOUT_CYCLES=16).
//   A run-length model of the ACK bit predicts every output each cycle; the
//   directed sequences also pin latencies and decisions with literal values.
//   Honours I2C_ACK_TIMEOUT_EN the same way the design does.
module tb_i2c_ack_monitor;

   localparam int unsigned S = 3;
   localparam int unsigned T = 16;
`ifdef I2C_ACK_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic wait_ack = 1'b0;
   logic SDA = 1'b0;
   logic BUS_CLK = 1'b0;
   logic ACK, N_ACK, ack_valid, busy, timeout;

   always #5 CLK = ~CLK;

   i2c_ack_monitor #(.SAMPLES(S), .TIMEOUT_CYCLES(T)) dut (
      .CLK(CLK), .RST(RST), .wait_ack(wait_ack), .SDA(SDA), .BUS_CLK(BUS_CLK),
      .ACK(ACK), .N_ACK(N_ACK), .ack_valid(ack_valid), .busy(busy), .timeout(timeout)
   );

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;
   int valid_seen = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_sda1, m_sda2, m_scl1, m_scl2;
   bit engaged, decided, low_seen;
   int hi_run, ones, elapsed;
   bit m_ack, m_nack, m_valid, m_tmo;

   always @(posedge CLK) begin
      bit sda_s, scl_s, timer_on;
      sda_s = m_sda2;
      scl_s = m_scl2;
      m_valid = 1'b0;
      m_tmo = 1'b0;
      if (RST) begin
         engaged = 0; decided = 0; low_seen = 0;
         hi_run = 0; ones = 0; elapsed = 0;
         m_ack = 0; m_nack = 0;
      end else if (!engaged && !decided) begin
         if (wait_ack) begin
            engaged = 1; low_seen = 0; hi_run = 0; ones = 0; elapsed = 0;
            m_ack = 0; m_nack = 0;
         end
      end else if (decided) begin
         if (!wait_ack) decided = 0;
      end else if (!wait_ack) begin
         engaged = 0;
      end else begin
         timer_on = (hi_run == 0);
         if (TMO_EN && timer_on && elapsed == int'(T) - 1) begin
            m_nack = 1; m_ack = 0; m_valid = 1; m_tmo = 1;
            engaged = 0; decided = 1;
         end else begin
            if (timer_on) elapsed++;
            if (!low_seen) begin
               if (!scl_s) low_seen = 1;
            end else if (scl_s) begin
               hi_run++;
               ones += int'(sda_s);
               if (hi_run == int'(S)) begin
                  m_nack = (ones > int'(S) / 2);
                  m_ack = !m_nack;
                  m_valid = 1;
                  engaged = 0; decided = 1;
               end
            end else begin
               hi_run = 0;
               ones = 0;
            end
         end
      end
      if (RST) begin
         m_sda1 = 0; m_sda2 = 0; m_scl1 = 0; m_scl2 = 0;
      end else begin
         m_sda2 = m_sda1; m_sda1 = SDA;
         m_scl2 = m_scl1; m_scl1 = BUS_CLK;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("ACK", ACK, m_ack);
         chk("N_ACK", N_ACK, m_nack);
         chk("ack_valid", ack_valid, m_valid);
         chk("busy", busy, engaged);
         chk("timeout", timeout, m_tmo);
         chk("ack_nack_exclusive", ACK & N_ACK, 0);
         if (ack_valid === 1'b1) valid_seen++;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic wait_valid(input int max, output int k);
      k = -1;
      for (int i = 1; i <= max; i++) begin
         @(posedge CLK);
         #1;
         if (ack_valid === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic run_bit(input logic [2:0] pat, input logic exp_n, input string tag);
      int v0;
      wait_ack = 1; tick(3);
      v0 = valid_seen;
      BUS_CLK = 1; SDA = pat[0]; tick(1);
      SDA = pat[1]; tick(1);
      SDA = pat[2]; tick(8);
      BUS_CLK = 0; tick(3);
      chk({tag, "_ack"}, ACK, !exp_n);
      chk({tag, "_nack"}, N_ACK, exp_n);
      chk({tag, "_pulses"}, valid_seen - v0, 1);
      wait_ack = 0; SDA = 0; tick(3);
   endtask

   initial begin
      int k, v0;
      tick(1);
      chk_en = 1;
      tick(2);
      chk("rst_busy", busy, 0);
      chk("rst_ack", ACK, 0);
      chk("rst_nack", N_ACK, 0);
      chk("rst_valid", ack_valid, 0);
      RST = 0; tick(2);

      // clean ACK, fixed latency, no second decision while still armed
      SDA = 0; wait_ack = 1; tick(3);
      v0 = valid_seen;
      BUS_CLK = 1;
      wait_valid(12, k);
      chk("ack_latency", k, 5);
      chk("ack_val", ACK, 1);
      chk("ack_nack", N_ACK, 0);
      tick(5); BUS_CLK = 0; tick(4);
      BUS_CLK = 1; tick(6); BUS_CLK = 0; tick(4);
      chk("done_single_decision", valid_seen - v0, 1);
      wait_ack = 0; tick(3);
      chk("idle_keeps_ack", ACK, 1);
      chk("idle_not_busy", busy, 0);

      run_bit(3'b111, 1'b1, "sda_high");
      run_bit(3'b010, 1'b0, "votes_010");   // pat[0] first: samples 0,1,0
      run_bit(3'b101, 1'b1, "votes_101");

      // glitch rejection then clean pulse
      wait_ack = 1; tick(3);
      v0 = valid_seen;
      BUS_CLK = 1; tick(2); BUS_CLK = 0; tick(3);
      chk("glitch_ignored", valid_seen - v0, 0);
      chk("glitch_still_busy", busy, 1);
      BUS_CLK = 1; SDA = 0; tick(10); BUS_CLK = 0; tick(3);
      chk("after_glitch_pulses", valid_seen - v0, 1);
      chk("after_glitch_ack", ACK, 1);
      wait_ack = 0; tick(3);

      // reset in the middle of filtering
      wait_ack = 1; tick(3);
      v0 = valid_seen;
      BUS_CLK = 1; tick(3);
      RST = 1; tick(1);
      chk("midrst_busy", busy, 0);
      chk("midrst_ack", ACK, 0);
      chk("midrst_nack", N_ACK, 0);
      RST = 0; wait_ack = 0; BUS_CLK = 0; tick(4);
      chk("midrst_no_valid", valid_seen - v0, 0);

      // leave N_ACK set, then abort from WAIT_RISE: arm must clear it
      run_bit(3'b111, 1'b1, "pre_abort");
      v0 = valid_seen;
      wait_ack = 1; tick(3);
      wait_ack = 0; tick(1);
      chk("abort_busy", busy, 0);
      chk("abort_nack", N_ACK, 0);
      chk("abort_ack", ACK, 0);
      tick(2);
      chk("abort_no_valid", valid_seen - v0, 0);

      // reset wins over wait_ack on the same edge
      RST = 1; wait_ack = 1; tick(1);
      chk("rst_prio_busy", busy, 0);
      RST = 0; wait_ack = 0; tick(2);

      // SCL held low after arm
      BUS_CLK = 0; wait_ack = 1;
      wait_valid(20, k);
      if (TMO_EN) begin
         chk("tmo_latency", k, 17);
         chk("tmo_pulse", timeout, 1);
         chk("tmo_nack", N_ACK, 1);
      end else begin
         chk("no_tmo_valid", k, -1);
         chk("no_tmo_busy", busy, 1);
         chk("no_tmo_pulse", timeout, 0);
      end
      wait_ack = 0; tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
